// File: rtl/rtc_uart_time_set.sv
// Serial time-set receiver: UART bytes framed as "T" HH MM SS CR become a BCD preset with a load strobe.
// Optional even-parity reception (8E1) is enabled by defining RTC_RX_PARITY_EN.
module rtc_uart_time_set #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       set_valid,
  output logic [1:0] set_hr1,
  output logic [3:0] set_hr0,
  output logic [2:0] set_min1,
  output logic [3:0] set_min0,
  output logic [2:0] set_sec1,
  output logic [3:0] set_sec0,
  output logic       frame_err,
  output logic       parse_err,
  output logic       busy
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

`ifdef RTC_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             rx_m, rx_s, rx_d;
  logic             byte_valid, frame_bad, stop_ok;
  logic [2:0]       idx_q;
  logic [3:0]       digits [6];
`ifdef RTC_RX_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  function automatic logic time_in_range(input logic [3:0] h1, input logic [3:0] h0,
                                         input logic [3:0] m1, input logic [3:0] s1);
    return ((h1 < 4'd2) || (h1 == 4'd2 && h0 <= 4'd3)) && (m1 <= 4'd5) && (s1 <= 4'd5);
  endfunction

  assign busy = (state_q != IDLE);

  // Stage: line synchroniser plus previous-value flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Stage: bit-level receiver state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
`ifdef RTC_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
`ifdef RTC_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_bad  = 1'b0;
`ifdef RTC_RX_PARITY_EN
    par_err_d  = par_err_q;
    stop_ok    = rx_s && !par_err_q;
`else
    stop_ok    = rx_s;
`endif
    case (state_q)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef RTC_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef RTC_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_err_d = ^{shreg_q, rx_s};
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (stop_ok) byte_valid = 1'b1;
          else         frame_bad  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage: frame parser and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      set_valid <= 1'b0;
      parse_err <= 1'b0;
      frame_err <= 1'b0;
      set_hr1   <= '0;
      set_hr0   <= '0;
      set_min1  <= '0;
      set_min0  <= '0;
      set_sec1  <= '0;
      set_sec0  <= '0;
    end else begin
      set_valid <= 1'b0;
      parse_err <= 1'b0;
      frame_err <= frame_bad;
      if (frame_bad) begin
        idx_q <= '0;
      end else if (byte_valid) begin
        if (idx_q == 3'd0) begin
          if (shreg_q == 8'h54) idx_q <= 3'd1;
        end else if (idx_q == 3'd7) begin
          idx_q <= '0;
          if (shreg_q == 8'h0D && time_in_range(digits[0], digits[1], digits[2], digits[4])) begin
            set_valid <= 1'b1;
            set_hr1   <= digits[0][1:0];
            set_hr0   <= digits[1];
            set_min1  <= digits[2][2:0];
            set_min0  <= digits[3];
            set_sec1  <= digits[4][2:0];
            set_sec0  <= digits[5];
          end else begin
            parse_err <= 1'b1;
          end
        end else if (shreg_q >= 8'h30 && shreg_q <= 8'h39) begin
          idx_q <= idx_q + 3'd1;
        end else if (shreg_q == 8'h54) begin
          idx_q <= 3'd1;
        end else begin
          idx_q     <= '0;
          parse_err <= 1'b1;
        end
      end
    end
  end

  // Digit buffer is pure data; the parser index alone decides what is valid
  always_ff @(posedge clk) begin
    if (byte_valid && idx_q != 3'd0 && idx_q != 3'd7 && shreg_q >= 8'h30 && shreg_q <= 8'h39)
      digits[idx_q - 3'd1] <= shreg_q[3:0];
  end

endmodule

// File: tb/tb_rtc_uart_time_set.sv
// Scoreboard bench for rtc_uart_time_set at 16 clocks per bit; parity stimulus follows RTC_RX_PARITY_EN.
module tb_rtc_uart_time_set;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       set_valid, frame_err, parse_err, busy;
  logic [1:0] set_hr1;
  logic [3:0] set_hr0, set_min0, set_sec0;
  logic [2:0] set_min1, set_sec1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  flags;   // {set_valid, parse_err, frame_err}
    logic [19:0] t;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [2:0]  mon_flags;
  logic [19:0] mon_t;

  rtc_uart_time_set #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .set_valid(set_valid), .set_hr1(set_hr1), .set_hr0(set_hr0),
    .set_min1(set_min1), .set_min0(set_min0), .set_sec1(set_sec1), .set_sec0(set_sec0),
    .frame_err(frame_err), .parse_err(parse_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] bcd_to_fields(input logic [23:0] b);
    return {b[21:20], b[19:16], b[14:12], b[11:8], b[6:4], b[3:0]};
  endfunction

  task automatic push(input logic [2:0] flags, input logic [23:0] bcd);
    exp_t x;
    x.flags = flags;
    x.t     = bcd_to_fields(bcd);
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic bad_par);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef RTC_RX_PARITY_EN
    rx_in = (^b) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    rx_in = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b0);
  endtask

  task automatic send_frame(input string s);
    send_str(s);
    send_byte(8'h0D, 1'b1, 1'b0);
  endtask

  // Monitor: every strobe must match the next queued expectation, including held set_* values
  always @(negedge clk) begin
    if (rst) begin
      mon_flags = {set_valid, parse_err, frame_err};
      mon_t     = {set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0};
      if (mon_flags != 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: flags=%b time=%h expected none", mon_flags, mon_t);
        end else begin
          e = exp_q.pop_front();
          if (mon_flags !== e.flags || mon_t !== e.t) begin
            errors++;
            $display("FAIL event: flags=%b time=%h expected flags=%b time=%h",
                     mon_flags, mon_t, e.flags, e.t);
          end
        end
      end
    end
  end

  int busy_cnt;

  initial begin
    // Scenario 1: reset and idle line
    repeat (5) @(negedge clk);
    check("reset_fields", {set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0}, 0);
    check("reset_strobes", {set_valid, parse_err, frame_err}, 0);
    check("reset_busy", busy, 0);
    rst = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);

    // Scenario 2: valid maximum time
    push(3'b100, 24'h235959);
    send_frame("T235959");

    // Scenario 3: out-of-range hours, then all zero
    push(3'b010, 24'h235959);
    send_frame("T240000");
    push(3'b100, 24'h000000);
    send_frame("T000000");

    // Scenario 4: bad digit, recovery, restart by mid-frame 'T'
    push(3'b010, 24'h000000);
    send_str("T12a");
    push(3'b100, 24'h013045);
    send_frame("T013045");
    push(3'b100, 24'h083000);
    send_frame("T12T083000");

    // Scenario 5: stop-bit error, then a clean frame
    send_byte(8'h54, 1'b1, 1'b0);
    push(3'b001, 24'h083000);
    send_byte(8'h31, 1'b0, 1'b0);
    push(3'b100, 24'h101010);
    send_frame("T101010");
`ifdef RTC_RX_PARITY_EN
    send_byte(8'h54, 1'b1, 1'b0);
    push(3'b001, 24'h101010);
    send_byte(8'h35, 1'b1, 1'b1);
    push(3'b100, 24'h215500);
    send_frame("T215500");
`endif

    // Scenario 6a: short low glitch on an idle line
    busy_cnt = 0;
    rx_in = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 3) rx_in = 1'b1;
    end
    check("glitch_busy_about_8", (busy_cnt >= 7 && busy_cnt <= 9), 1);
    check("glitch_busy_low_after", busy, 0);

    // Scenario 6b: reset while inside the data bits
    rx_in = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    check("busy_in_data", busy, 1);
    rst = 1'b0;
    #1;
    check("busy_async_reset", busy, 0);
    check("fields_async_reset", {set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0}, 0);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (CPB * 4) @(negedge clk);
    push(3'b100, 24'h123456);
    send_frame("T123456");

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_uart_time_set.md
Name: rtc_uart_time_set

Overview:
Serial time-set front end for the RTC. It receives 8N1 UART bytes on a single input line and parses ASCII frames of the form "T" HH MM SS CR. Validated times are presented as BCD digit fields with a one-cycle load strobe, which the clock counters take as a preset. This is the inbound path, complementing the display/button path: it writes the time rather than showing it.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); minimum 4.
HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit mid-sample.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset
rx_in  in  1  UART line, idle high, asynchronous to clk
set_valid  out  1  one-cycle strobe; set_* fields hold a new validated time
set_hr1  out  2  hours tens, 0-2
set_hr0  out  4  hours units, 0-9
set_min1  out  3  minutes tens, 0-5
set_min0  out  4  minutes units, 0-9
set_sec1  out  3  seconds tens, 0-5
set_sec0  out  4  seconds units, 0-9
frame_err  out  1  one-cycle strobe; bad start or stop bit (or parity, see Optional Feature)
parse_err  out  1  one-cycle strobe; frame content rejected
busy  out  1  high while the RX FSM is not in IDLE

Behaviour:
- Reset values: all set_* = 0; set_valid, frame_err, parse_err, busy = 0; synchroniser flops = 1; RX FSM = IDLE; parser index = 0.
- rx_in passes through a 2-flop synchroniser (rx_s). A third flop holds the previous value for edge detection.
- RX FSM states: IDLE, START, DATA, STOP. Bit-cycle counter width is clog2(CLKS_PER_BIT); bit index is 3 bits.
  - IDLE -> START on an rx_s falling edge (1 -> 0). A line that is already low does not start a byte.
  - START: wait HALF_BIT-1 cycles, then sample. If low -> DATA. If high -> IDLE as a glitch, with no error.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
  - STOP: sample after CLKS_PER_BIT cycles. High -> internal byte_valid for one cycle. Low -> frame_err pulse, byte discarded, parser index forced to 0. Both outcomes then go to IDLE.
- Parser, index 0-7, acts only on byte_valid:
  - idx 0: byte 0x54 ('T') -> idx 1. Any other byte is ignored silently.
  - idx 1-6: byte 0x30-0x39 -> store (byte - 0x30) into digit buffer[idx-1], idx+1. Byte 0x54 -> idx 1, restarting the frame with no error. Anything else -> parse_err, idx 0.
  - idx 7: byte 0x0D, with the buffered values in range (HH <= 23 as a two-digit number, MM <= 59, SS <= 59) -> copy the buffer to set_* and pulse set_valid. Out-of-range values or any non-CR byte -> parse_err. All outcomes return to idx 0.
- Latency: set_valid and the new set_* values appear on the cycle after byte_valid for the CR byte, i.e. 1 cycle after stop-bit sampling.
- set_* change only on set_valid and otherwise hold their last accepted value. The digit buffer is separate from the outputs, so partial frames are never visible.
- At most one of set_valid, parse_err, frame_err is high in any cycle.
- Reset asserted mid-byte or mid-frame: immediate return to reset values. A partial frame is lost, and the next byte must start with a fresh falling edge.
- Digit widths are truncated into the output fields only after the range check passes, so no overflow is possible.

Optional Feature:
Macro: RTC_RX_PARITY_EN.
- Defined: the RX FSM adds a PARITY state between DATA and STOP, so a frame is 8E1. One sample is taken after CLKS_PER_BIT cycles. If the XOR of the 8 data bits and the parity bit is 1, the FSM still consumes the stop bit, then pulses frame_err, discards the byte and resets the parser to idx 0.
- Undefined: 8N1 as above, with no PARITY state.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Reset with rx_in=1 -> all outputs 0; busy stays 0 for 1000 cycles.
2. Send "T235959" followed by 0x0D -> exactly one set_valid pulse; hr1=2, hr0=3, min1=5, min0=9, sec1=5, sec0=9; no error pulses.
3. After scenario 2, send "T240000" followed by CR -> one parse_err pulse; set_* remain 23:59:59. Then send "T000000" followed by CR -> set_valid with all fields 0.
4. Send "T12a" -> parse_err on 'a'. Then send "T013045" followed by CR -> set_valid with 01:30:45. Then send "T12T083000" followed by CR -> no parse_err; set_valid with 08:30:00.
5. Send 'T', then a byte with stop bit 0, then "T101010" followed by CR -> frame_err once; then set_valid with 10:10:10. With RTC_RX_PARITY_EN: send '5' with wrong parity -> frame_err; next correct frame is accepted.
6. Pull rx_in low for 3 cycles on an idle line -> busy high about 8 cycles then low; no byte and no error. Assert rst during the DATA state -> busy=0 immediately; the next full frame is accepted.
